// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Streams signed 18x18 operand pairs into one DSP48A1 slice set up as a
// multiply-accumulator and returns one 48-bit dot product per vector.
// The slice has A1REG=B1REG=OPMODEREG=PREG=1, so P reflects a presented beat
// LAT cycles later.
//
// Ports
//   CLK, RST                  clock, asynchronous active-high reset
//   s_valid/s_ready           operand stream handshake
//   s_a, s_b                  signed operands
//   s_last                    marks the final pair of a vector
//   m_valid/m_ready           result handshake
//   m_result, m_count         accumulated sum, number of beats in the vector
//   m_trunc                   vector was closed at MAX_LEN without s_last
//   dsp_A, dsp_B, dsp_OPMODE  slice operand and opcode inputs
//   dsp_RST                   slice synchronous resets
//   dsp_P                     slice accumulator output
module dsp_mac_sequencer #(
    parameter int LAT     = 2,
    parameter int MAX_LEN = 4096,
    parameter int CNT_W   = 13
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [47:0]      m_result,
    output logic [CNT_W-1:0] m_count,
    output logic             m_trunc,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_RST,
    input  logic [47:0]      dsp_P
);

    localparam int FW = $clog2(LAT + 2);

    typedef enum logic [2:0] {FLUSH, IDLE, ACCUM, DRAIN, HOLD} state_t;

    typedef struct packed {
        logic [47:0]      result;
        logic [CNT_W-1:0] count;
        logic             trunc;
    } res_t;

    state_t           state, state_nxt;
    res_t             res_q;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [FW-1:0]    flush_cnt;
    logic             trunc_q;
    logic             accept, at_max, close_vec;
    // vld_pipe[0] marks the closing beat; vld_pipe[LAT] is the cycle in which
    // P holds the complete sum for that vector.
    logic [LAT:0]     vld_pipe;
    logic [LAT:1]     vld_q;

    assign accept    = s_valid & s_ready;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign at_max    = (cnt_inc == CNT_W'(MAX_LEN));
    assign close_vec = accept & (s_last | at_max);
    assign vld_pipe  = {vld_q, close_vec};

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= FLUSH;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH: if (flush_cnt == FW'(LAT)) state_nxt = IDLE;
            IDLE:  if (accept) state_nxt = close_vec ? DRAIN : ACCUM;
            ACCUM: if (close_vec) state_nxt = DRAIN;
            DRAIN: if (vld_pipe[LAT]) state_nxt = HOLD;
            HOLD:  if (m_ready) state_nxt = IDLE;
            default: state_nxt = FLUSH;
        endcase
    end

    // outputs
    always_comb begin
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        dsp_RST    = 1'b0;
        dsp_OPMODE = 8'h00;
        dsp_A      = accept ? s_a : 18'd0;
        dsp_B      = accept ? s_b : 18'd0;
        case (state)
            FLUSH: dsp_RST = 1'b1;
            IDLE: begin
                s_ready    = 1'b1;
                dsp_OPMODE = accept ? 8'h01 : 8'h00;
            end
            ACCUM: begin
                s_ready    = 1'b1;
                dsp_OPMODE = accept ? 8'h09 : 8'h08;
            end
            DRAIN: dsp_OPMODE = 8'h08;
            HOLD: begin
                m_valid    = 1'b1;
                dsp_OPMODE = 8'h08;
            end
            default: ;
        endcase
    end

    // beat counter, flush timer, latency pipe and result register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            trunc_q   <= 1'b0;
            flush_cnt <= '0;
            vld_q     <= '0;
            res_q     <= '0;
        end else begin
            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
            vld_q     <= vld_pipe[LAT-1:0];
            if (accept) begin
                cnt <= cnt_inc;
                // s_last on the MAX_LEN-th beat is a normal close
                if (close_vec) trunc_q <= at_max & ~s_last;
            end
            if (state == HOLD && m_ready) cnt <= '0;
            if (vld_pipe[LAT])
                res_q <= '{result: dsp_P, count: cnt, trunc: trunc_q};
        end
    end

    assign m_result = res_q.result;
    assign m_count  = res_q.count;
    assign m_trunc  = res_q.trunc;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two instances (MAX_LEN=4096 and MAX_LEN=4),
// each feeding a behavioural DSP48A1 slice model. Expected results are queued
// at stimulus time and checked by a monitor on each result handshake.
module tb_dsp_mac_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        s_valid = 1'b0, s_last = 1'b0;
    logic [17:0] s_a = '0, s_b = '0;
    int          sel = 0;
    logic        mr0 = 1'b1, mr1 = 1'b1;
    logic        sv0, sv1, cur_ready;

    logic        rdy0, mv0, tr0, drst0;
    logic [47:0] res0, p0;
    logic [12:0] cnt0;
    logic [17:0] a0, b0;
    logic [7:0]  op0;

    logic        rdy1, mv1, tr1, drst1;
    logic [47:0] res1, p1;
    logic [2:0]  cnt1;
    logic [17:0] a1, b1;
    logic [7:0]  op1;

    assign sv0       = s_valid && (sel == 0);
    assign sv1       = s_valid && (sel == 1);
    assign cur_ready = (sel == 0) ? rdy0 : rdy1;

    dsp_mac_sequencer #(.LAT(2), .MAX_LEN(4096), .CNT_W(13)) u_dut0 (
        .CLK(clk), .RST(rst), .s_valid(sv0), .s_ready(rdy0), .s_a(s_a), .s_b(s_b),
        .s_last(s_last), .m_valid(mv0), .m_ready(mr0), .m_result(res0), .m_count(cnt0),
        .m_trunc(tr0), .dsp_A(a0), .dsp_B(b0), .dsp_OPMODE(op0), .dsp_RST(drst0), .dsp_P(p0)
    );

    dsp_mac_sequencer #(.LAT(2), .MAX_LEN(4), .CNT_W(3)) u_dut1 (
        .CLK(clk), .RST(rst), .s_valid(sv1), .s_ready(rdy1), .s_a(s_a), .s_b(s_b),
        .s_last(s_last), .m_valid(mv1), .m_ready(mr1), .m_result(res1), .m_count(cnt1),
        .m_trunc(tr1), .dsp_A(a1), .dsp_B(b1), .dsp_OPMODE(op1), .dsp_RST(drst1), .dsp_P(p1)
    );

    // Slice models: A1/B1/OPMODE register stage, combinational multiplier,
    // P register. X=01 selects the product, Z=10 selects P.
    logic signed [17:0] a0r, b0r, a1r, b1r;
    logic [7:0]         op0r, op1r;
    logic signed [35:0] m0, m1;
    assign m0 = a0r * b0r;
    assign m1 = a1r * b1r;

    always @(posedge clk) begin
        if (drst0) begin
            a0r <= '0; b0r <= '0; op0r <= '0; p0 <= '0;
        end else begin
            a0r <= a0; b0r <= b0; op0r <= op0;
            p0  <= ((op0r[3:2] == 2'b10) ? p0 : 48'd0) +
                   ((op0r[1:0] == 2'b01) ? {{12{m0[35]}}, m0} : 48'd0);
        end
    end

    always @(posedge clk) begin
        if (drst1) begin
            a1r <= '0; b1r <= '0; op1r <= '0; p1 <= '0;
        end else begin
            a1r <= a1; b1r <= b1; op1r <= op1;
            p1  <= ((op1r[3:2] == 2'b10) ? p1 : 48'd0) +
                   ((op1r[1:0] == 2'b01) ? {{12{m1[35]}}, m1} : 48'd0);
        end
    end

    typedef struct {
        logic [47:0] r;
        int          c;
        bit          t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // result monitors
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && mv0 && mr0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected got r=%0h c=%0d t=%0d", res0, cnt0, tr0);
            end else begin
                e = q0.pop_front();
                if (res0 !== e.r || int'(cnt0) != e.c || tr0 !== e.t) begin
                    errors++;
                    $display("FAIL dut0_result got r=%0h c=%0d t=%0d want r=%0h c=%0d t=%0d",
                             res0, cnt0, tr0, e.r, e.c, e.t);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && mv1 && mr1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected got r=%0h c=%0d t=%0d", res1, cnt1, tr1);
            end else begin
                e = q1.pop_front();
                if (res1 !== e.r || int'(cnt1) != e.c || tr1 !== e.t) begin
                    errors++;
                    $display("FAIL dut1_result got r=%0h c=%0d t=%0d want r=%0h c=%0d t=%0d",
                             res1, cnt1, tr1, e.r, e.c, e.t);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [47:0] r, input int c, input bit t);
        exp_t e;
        e.r = r; e.c = c; e.t = t;
        return e;
    endfunction

    // present one beat until accepted; returns the OPMODE seen in the accept cycle
    task automatic beat(input logic [17:0] a, input logic [17:0] b, input logic last,
                        output logic [7:0] op);
        bit ok = 0;
        op = '0;
        s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cur_ready) begin
                ok = 1;
                op = (sel == 0) ? op0 : op1;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL beat_timeout got ready=0 want ready=1");
        end
    endtask

    // returns at the negedge where m_valid is first seen high
    task automatic wait_mv();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if ((sel == 0) ? mv0 : mv1) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL mvalid_timeout got m_valid=0 want m_valid=1");
        end
    endtask

    task automatic gap2();
        repeat (2) begin
            @(negedge clk);
            chk("gap_opmode", op0, 8'h08);
            chk("gap_a", a0, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic vec28(input bit gaps);
        logic [7:0] op;
        beat(18'd3, 18'd4, 1'b0, op);
        chk("op_first", op, 8'h01);
        if (gaps) gap2();
        beat(18'd5, 18'd6, 1'b0, op);
        chk("op_next", op, 8'h09);
        if (gaps) gap2();
        beat(-18'sd2, 18'd7, 1'b1, op);
        chk("op_last", op, 8'h09);
    endtask

    initial begin : stim
        logic [7:0] op;

        // reset state
        @(negedge clk);
        chk("reset_ctl0", {rdy0, mv0, tr0, drst0}, 4'b0001);
        chk("reset_data0", {res0, cnt0}, 0);
        chk("reset_dsp0", {a0, b0, op0}, 0);
        chk("reset_ctl1", {rdy1, mv1, tr1, drst1}, 4'b0001);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("flush0_rst", drst0, 1);
        chk("flush0_ready", rdy0, 0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("flush%0d_rst", i), drst0, (i < 3) ? 1 : 0);
            chk($sformatf("flush%0d_ready", i), rdy0, (i == 3) ? 1 : 0);
        end

        // contiguous vector and latency
        sel = 0;
        q0.push_back(mk(48'd28, 3, 0));
        vec28(0);
        @(negedge clk);
        chk("lat_c1_valid", mv0, 0);
        chk("lat_c1_ready", rdy0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_c2_valid", mv0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_c3_valid", mv0, 1);
        @(posedge clk); #1;

        // gaps between beats
        q0.push_back(mk(48'd28, 3, 0));
        vec28(1);
        wait_mv();
        @(posedge clk); #1;

        // backpressure
        mr0 = 1'b0;
        q0.push_back(mk(48'd28, 3, 0));
        vec28(0);
        wait_mv();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", mv0, 1);
            chk("bp_result", res0, 48'd28);
            chk("bp_ready", rdy0, 0);
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        mr0 = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", rdy0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_after_ready", rdy0, 1);
        chk("bp_after_valid", mv0, 0);
        @(posedge clk); #1;

        // truncation at MAX_LEN=4; 5th beat opens a new vector
        sel = 1;
        q1.push_back(mk(48'd4, 4, 1));
        q1.push_back(mk(48'd7, 2, 0));
        repeat (4) beat(18'd1, 18'd1, 1'b0, op);
        beat(18'd1, 18'd1, 1'b0, op);
        chk("trunc_new_vec_op", op, 8'h01);
        beat(18'd2, 18'd3, 1'b1, op);
        wait_mv();
        @(posedge clk); #1;
        // s_last on the MAX_LEN-th beat is not truncation
        q1.push_back(mk(48'd10, 4, 0));
        beat(18'd1, 18'd1, 1'b0, op);
        beat(18'd1, 18'd2, 1'b0, op);
        beat(18'd1, 18'd3, 1'b0, op);
        beat(18'd1, 18'd4, 1'b1, op);
        wait_mv();
        @(posedge clk); #1;

        // extremes: 4096 x (-2^17)^2 = 2^46
        sel = 0;
        q0.push_back(mk(48'h4000_0000_0000, 4096, 0));
        for (int i = 0; i < 4096; i++)
            beat(18'h20000, 18'h20000, (i == 4095), op);
        wait_mv();
        chk("ext_sign", res0[47], 0);
        @(posedge clk); #1;

        // reset mid-vector
        beat(18'd3, 18'd4, 1'b0, op);
        beat(18'd5, 18'd6, 1'b0, op);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", mv0, 0);
        chk("rst_mid_dsprst", drst0, 1);
        chk("rst_mid_ready", rdy0, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        q0.push_back(mk(48'd28, 3, 0));
        vec28(0);
        wait_mv();
        @(posedge clk); #1;

        // reset mid-HOLD: the held result is discarded
        mr0 = 1'b0;
        beat(18'd1, 18'd1, 1'b1, op);
        wait_mv();
        #2 rst = 1'b1;
        #1;
        chk("rst_hold_valid", mv0, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        mr0 = 1'b1;
        q0.push_back(mk(48'd14, 2, 0));
        beat(18'd2, -18'sd3, 1'b0, op);
        beat(18'd4, 18'd5, 1'b1, op);
        wait_mv();
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
